// File: rtl/float_signed_to_float_pipe.sv
// Converts a sign / two's-complement exponent / fraction triple into an IEEE-style
// float. Two stages: align + guard/round/sticky extraction, then round, normalize, pack.
module float_signed_to_float_pipe #(
  parameter int SIGNED_EXP  = 6,
  parameter int SIGNED_FRAC = 11,
  parameter int EXP         = 8,
  parameter int FRAC        = 23,
  parameter int DENORMALS   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sign,
  input  logic signed [SIGNED_EXP-1:0]  in_exp,
  input  logic        [SIGNED_FRAC-1:0] in_frac,
  input  logic                          in_isZero,
  input  logic                          in_isInf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [EXP+FRAC:0]      out_data,
  output logic        [15:0]            ovf_count,
  output logic        [15:0]            unf_count
);
  localparam int BW    = ((SIGNED_EXP > EXP) ? SIGNED_EXP : EXP) + 2;
  localparam int EXT   = (SIGNED_FRAC > FRAC) ? SIGNED_FRAC - FRAC : 0;
  localparam int XW    = FRAC + 3 + EXT;
  localparam int SHMAX = FRAC + 3;
  localparam int YW    = XW + SHMAX;
  localparam int SHW   = $clog2(SHMAX + 1);

  localparam logic        [BW-1:0]  BIAS   = BW'((1 << (EXP - 1)) - 1);
  localparam logic signed [BW-1:0]  MAXE   = BW'((1 << EXP) - 1);
  localparam logic signed [BW-1:0]  ONE    = BW'(1);
  localparam logic signed [BW-1:0]  SH_LIM = BW'(SHMAX);
  localparam logic        [SHW-1:0] SH_CAP = SHW'(SHMAX);

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          inf;
    logic          tiny;
    logic [BW-1:0] exp;
    logic [FRAC:0] mant;
    logic          g;
    logic          r;
    logic          st;
  } s1_t;

  logic                    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                    s1_advance, accept, load2;
  s1_t                     s1_q, s1_d;
  logic [EXP+FRAC:0]       out_data_q, out_data_d;
  logic [15:0]             ovf_count_q, ovf_count_d, unf_count_q, unf_count_d;

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;
  assign load2      = s1_valid_q && s1_advance;

  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;
  assign ovf_count  = ovf_count_q;
  assign unf_count  = unf_count_q;

  // Stage 1: bias the exponent and pre-shift tiny values so that stage 2 only rounds.
  logic signed [BW-1:0] b1, diff;
  logic                 tiny;
  logic [SHW-1:0]       sh;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;

  always_comb begin
    b1   = $signed({{(BW-SIGNED_EXP){in_exp[SIGNED_EXP-1]}}, in_exp} + BIAS);
    diff = ONE - b1;
    tiny = b1[BW-1] || (b1 == '0);
    sh   = '0;
    if (tiny && DENORMALS != 0)
      sh = (diff > SH_LIM) ? SH_CAP : diff[SHW-1:0];
    // Significand with hidden one sits at the top; a capped shift still leaves it in sticky.
    x = {1'b1, in_frac, {(XW-SIGNED_FRAC-1){1'b0}}};
    y = {x, {SHMAX{1'b0}}} >> sh;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_d.sign = in_sign;
      s1_d.zero = in_isZero;
      s1_d.inf  = in_isInf;
      s1_d.tiny = tiny;
      s1_d.exp  = b1;
      s1_d.mant = y[YW-1 -: FRAC+1];
      s1_d.g    = y[YW-FRAC-2];
      s1_d.r    = y[YW-FRAC-3];
      s1_d.st   = |y[YW-FRAC-4:0];
    end
  end

  // Stage 2: round to nearest even, fix up exponent on carry, classify and pack.
  logic                 rnd, ovf_hit, unf_hit;
  logic [FRAC+1:0]      sum;
  logic signed [BW-1:0] en;
  logic [FRAC-1:0]      fr;
  logic [EXP+FRAC:0]    res;

  always_comb begin
    rnd     = s1_q.g & (s1_q.r | s1_q.st | s1_q.mant[0]);
    sum     = {1'b0, s1_q.mant} + {{(FRAC+1){1'b0}}, rnd};
    en      = s1_q.exp;
    fr      = sum[FRAC-1:0];
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (s1_q.tiny) begin
      en = sum[FRAC] ? ONE : '0;
    end else if (sum[FRAC+1]) begin
      en = s1_q.exp + ONE;
      fr = '0;
    end

    if (s1_q.inf) begin
      res = {s1_q.sign, {EXP{1'b1}}, {FRAC{1'b0}}};
    end else if (s1_q.zero) begin
      res = {s1_q.sign, {(EXP+FRAC){1'b0}}};
    end else if (s1_q.tiny && (DENORMALS == 0 || (en == '0 && fr == '0))) begin
      res     = {s1_q.sign, {(EXP+FRAC){1'b0}}};
      unf_hit = 1'b1;
    end else if (en >= MAXE) begin
      res     = {s1_q.sign, {EXP{1'b1}}, {FRAC{1'b0}}};
      ovf_hit = 1'b1;
    end else begin
      res = {s1_q.sign, en[EXP-1:0], fr};
    end

    s2_valid_d  = s1_advance ? s1_valid_q : s2_valid_q;
    out_data_d  = load2 ? res : out_data_q;
    ovf_count_d = ovf_count_q;
    unf_count_d = unf_count_q;
    if (load2 && ovf_hit && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    if (load2 && unf_hit && unf_count_q != 16'hFFFF) unf_count_d = unf_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      ovf_count_q <= '0;
      unf_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      ovf_count_q <= ovf_count_d;
      unf_count_q <= unf_count_d;
    end
  end

  always_ff @(posedge clock) s1_q <= s1_d;

endmodule

// File: tb/tb_float_signed_to_float_pipe.sv
// Directed bench: one default-format instance and two half-precision instances
// (denormals kept / flushed) sharing the clock and reset.
module tb_float_signed_to_float_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default 6/11 -> 8/23 instance
  logic               sp_in_valid, sp_in_ready, sp_sign, sp_zero, sp_inf;
  logic signed [5:0]  sp_exp;
  logic [10:0]        sp_frac;
  logic               sp_out_valid, sp_out_ready;
  logic [31:0]        sp_out_data;
  logic [15:0]        sp_ovf, sp_unf;

  // half-precision instances share their inputs
  logic               h_in_valid, h_sign, h_zero, h_inf;
  logic signed [5:0]  h_exp;
  logic [10:0]        h_frac;
  logic               h_out_ready;
  logic               hf_in_ready, hf_out_valid, hz_in_ready, hz_out_valid;
  logic [15:0]        hf_out_data, hz_out_data;
  logic [15:0]        hf_ovf, hf_unf, hz_ovf, hz_unf;

  float_signed_to_float_pipe u_sp (
    .clock(clk), .reset(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .in_sign(sp_sign), .in_exp(sp_exp), .in_frac(sp_frac), .in_isZero(sp_zero),
    .in_isInf(sp_inf), .out_valid(sp_out_valid), .out_ready(sp_out_ready),
    .out_data(sp_out_data), .ovf_count(sp_ovf), .unf_count(sp_unf));

  float_signed_to_float_pipe #(.EXP(5), .FRAC(10), .DENORMALS(1)) u_hf (
    .clock(clk), .reset(rst), .in_valid(h_in_valid), .in_ready(hf_in_ready),
    .in_sign(h_sign), .in_exp(h_exp), .in_frac(h_frac), .in_isZero(h_zero),
    .in_isInf(h_inf), .out_valid(hf_out_valid), .out_ready(h_out_ready),
    .out_data(hf_out_data), .ovf_count(hf_ovf), .unf_count(hf_unf));

  float_signed_to_float_pipe #(.EXP(5), .FRAC(10), .DENORMALS(0)) u_hz (
    .clock(clk), .reset(rst), .in_valid(h_in_valid), .in_ready(hz_in_ready),
    .in_sign(h_sign), .in_exp(h_exp), .in_frac(h_frac), .in_isZero(h_zero),
    .in_isInf(h_inf), .out_valid(hz_out_valid), .out_ready(h_out_ready),
    .out_data(hz_out_data), .ovf_count(hz_ovf), .unf_count(hz_unf));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic sp_set(input bit s, input int e, input int f, input bit z, input bit i);
    sp_sign = s; sp_exp = 6'(e); sp_frac = 11'(f); sp_zero = z; sp_inf = i;
    sp_in_valid = 1'b1;
  endtask

  // one beat through an idle default pipe; result sampled two edges after acceptance
  task automatic sp_one(input bit s, input int e, input int f, input bit z, input bit i,
                        output logic v, output logic [31:0] d);
    @(negedge clk); sp_set(s, e, f, z, i);
    @(posedge clk); @(negedge clk); sp_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    v = sp_out_valid; d = sp_out_data;
  endtask

  task automatic h_one(input bit s, input int e, input int f, input bit z, input bit i);
    @(negedge clk);
    h_sign = s; h_exp = 6'(e); h_frac = 11'(f); h_zero = z; h_inf = i; h_in_valid = 1'b1;
    @(posedge clk); @(negedge clk); h_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [31:0] stream_exp(input int k);
    logic [7:0]  e;
    logic [10:0] f;
    e = 8'(124 + k);
    f = 11'(k * 37 + 5);
    return {1'(k & 1), e, f, 12'b0};
  endfunction

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    logic        v;
    logic [31:0] d;
    int          pk, pguard, got, cyc;
    logic        prev_stall;
    logic [31:0] prev_data;

    rst = 1'b1;
    sp_in_valid = 1'b0; sp_out_ready = 1'b1; sp_sign = 0; sp_exp = 0; sp_frac = 0;
    sp_zero = 0; sp_inf = 0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_sign = 0; h_exp = 0; h_frac = 0;
    h_zero = 0; h_inf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", sp_out_valid, 0);
    check("rst_out_data", sp_out_data, 0);
    check("rst_hf_counts", {hf_ovf, hf_unf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", sp_in_ready, 1);

    // latency: not visible one edge after acceptance, visible after two
    @(negedge clk); sp_set(0, -3, 'h400, 0, 0);
    @(posedge clk); @(negedge clk); sp_in_valid = 1'b0;
    check("lat_early_valid", sp_out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("lat_valid", sp_out_valid, 1);
    check("lat_data", sp_out_data, 32'h3E400000);

    sp_one(1, 0, 0, 1, 1, v, d);
    check("sp_inf_neg", {v, d}, {1'b1, 32'hFF800000});
    sp_one(1, 5, 'h123, 1, 0, v, d);
    check("sp_zero_neg", {v, d}, {1'b1, 32'h80000000});
    sp_one(0, 31, 'h7FF, 0, 0, v, d);
    check("sp_max", {v, d}, {1'b1, 32'h4F7FF000});
    check("sp_counts", {sp_ovf, sp_unf}, 0);

    // half precision, normal rounding
    h_one(0, 0, 'h003, 0, 0);
    check("h_rnd_up", {hf_out_valid, hf_out_data}, {1'b1, 16'h3C02});
    h_one(0, 0, 'h001, 0, 0);
    check("h_tie_even", hf_out_data, 16'h3C00);
    h_one(0, 0, 'h7FF, 0, 0);
    check("h_carry", hf_out_data, 16'h4000);
    check("h_counts0", {hf_ovf, hf_unf, hz_ovf, hz_unf}, 0);
    h_one(0, 16, 0, 0, 0);
    check("h_ovf_data", hf_out_data, 16'h7C00);
    check("h_ovf_cnt", {hf_ovf, hz_ovf}, {16'd1, 16'd1});
    h_one(0, -15, 0, 0, 0);
    check("hf_denorm", hf_out_data, 16'h0200);
    check("hz_flush", hz_out_data, 16'h0000);
    check("h_unf_cnt1", {hf_unf, hz_unf}, {16'd0, 16'd1});
    h_one(1, 16, 0, 1, 1);
    check("h_inf_neg", {hf_out_data, hz_out_data}, {16'hFC00, 16'hFC00});
    check("h_inf_nocnt", {hf_ovf, hz_ovf}, {16'd1, 16'd1});
    h_one(1, -32, 0, 0, 0);
    check("h_tiny_zero", {hf_out_data, hz_out_data}, {16'h8000, 16'h8000});
    check("h_unf_cnt2", {hf_unf, hz_unf}, {16'd1, 16'd2});
    h_one(0, -15, 'h7FF, 0, 0);
    check("hf_denorm_carry", hf_out_data, 16'h0400);
    check("hz_flush2", hz_out_data, 16'h0000);
    check("h_unf_cnt3", {hf_unf, hz_unf}, {16'd1, 16'd3});
    h_one(1, -32, 'h7FF, 1, 0);
    check("h_zero_neg", {hf_out_data, hz_out_data}, {16'h8000, 16'h8000});
    check("h_zero_nocnt", {hf_unf, hz_unf}, {16'd1, 16'd3});

    // stream with random backpressure
    prev_stall = 1'b0; prev_data = '0;
    fork
      begin
        pk = 0; pguard = 0;
        while (pk < 8 && pguard < 200) begin
          @(negedge clk); #1;
          sp_set(1'(pk & 1), pk - 3, pk * 37 + 5, 0, 0);
          if (sp_in_ready) pk++;
          pguard++;
        end
        @(negedge clk); #1; sp_in_valid = 1'b0;
      end
      begin
        got = 0; cyc = 0;
        while (got < 8 && cyc < 300) begin
          @(negedge clk);
          sp_out_ready = 1'($urandom_range(0, 1));
          cyc++;
          if (prev_stall) check("stall_hold", {sp_out_valid, sp_out_data}, {1'b1, prev_data});
          if (sp_out_valid && sp_out_ready) begin
            check("stream_data", sp_out_data, stream_exp(got));
            got++;
          end
          prev_stall = sp_out_valid && !sp_out_ready;
          prev_data  = sp_out_data;
        end
      end
    join
    check("stream_count", got, 8);
    sp_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // full throughput with out_ready held high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        check("tp_in_ready", sp_in_ready, 1);
        sp_set(1'(i & 1), i - 3, i * 37 + 5, 0, 0);
      end else begin
        sp_in_valid = 1'b0;
      end
      if (i >= 2) check("tp_out", {sp_out_valid, sp_out_data}, {1'b1, stream_exp(i - 2)});
    end

    // fill both stages, then reset for one edge
    @(negedge clk); sp_in_valid = 1'b0; sp_out_ready = 1'b0;
    @(negedge clk); sp_set(0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); sp_set(0, 1, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    check("full_in_ready", sp_in_ready, 0);
    sp_set(0, 2, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; sp_in_valid = 1'b0;
    check("rr_out_valid", sp_out_valid, 0);
    check("rr_in_ready", sp_in_ready, 1);
    check("rr_out_data", sp_out_data, 0);
    check("rr_counts", {hf_ovf, hf_unf, hz_ovf, hz_unf}, 0);
    @(posedge clk); @(negedge clk);
    check("rr_no_ghost", sp_out_valid, 0);
    sp_out_ready = 1'b1;
    sp_set(0, 1, 0, 0, 0);
    @(posedge clk); @(negedge clk); sp_in_valid = 1'b0;
    check("rr_lat_early", sp_out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("rr_new_beat", {sp_out_valid, sp_out_data}, {1'b1, 32'h40000000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
